// File: rtl/skipring_mc.sv
// skipring_mc: multi-channel, variable-length pulse-skip ring.
//
// A shared position pointer walks 0..len_q-1, one position per cycle with E
// high. Each channel emits a one-cycle clock-enable strobe on the steps where
// its live mask bit at the current position is 1. This block produces enable
// strobes only; it never gates a clock.
//
// Mask and length updates are written into shadow registers by LOAD. They
// become live only on a wrap step, so every pattern period runs unbroken.
//
// Ports:
//   iCLK     system clock, all logic on posedge
//   RST      synchronous reset, active-high
//   E        advance enable, one ring step per cycle sampled high
//   LOAD     capture MASK_IN / LEN_SEL into the shadow registers
//   MASK_IN  per-channel masks, channel c = MASK_IN[c*LEN +: LEN], bit i = position i
//   LEN_SEL  requested ring length; 0 or a value above LEN selects LEN
//   oSTB     registered one-cycle strobe per channel
//   oB0      live mask bit at the current position (register-only path)
//   oWRAP    registered one-cycle pulse when the last position is consumed
//   oPOS     current position pointer
//   oCNT     per-channel 16-bit strobe counters
//
// Build option:
//   SKIPRING_MC_CNT_EN  when defined, oCNT[c*16 +: 16] counts cycles with
//                       oSTB[c]=1 (wrapping at 0xFFFF); when undefined the
//                       counters are not built and oCNT is tied to 0.

module skipring_mc #(
    parameter int              LEN          = 16,
    parameter int              NCH          = 2,
    parameter logic [LEN-1:0]  DEFAULT_MASK = 16'b0011010001000101
) (
    input  logic                       iCLK,
    input  logic                       RST,
    input  logic                       E,
    input  logic                       LOAD,
    input  logic [NCH*LEN-1:0]         MASK_IN,
    input  logic [$clog2(LEN+1)-1:0]   LEN_SEL,
    output logic [NCH-1:0]             oSTB,
    output logic [NCH-1:0]             oB0,
    output logic                       oWRAP,
    output logic [$clog2(LEN)-1:0]     oPOS,
    output logic [NCH*16-1:0]          oCNT
);

    localparam int LW = $clog2(LEN + 1);
    localparam int PW = $clog2(LEN);

    logic [LEN-1:0] live   [NCH];
    logic [LEN-1:0] shadow [NCH];
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  shadow_len;
    logic [LW-1:0]  len_in;
    logic           pend;
    logic [PW-1:0]  pos;
    logic [PW-1:0]  pos_nxt;
    logic           last_pos;
    logic           wrap_step;

    // Out-of-range requests fall back to the full ring.
    always_comb begin
        len_in = LEN_SEL;
        if (LEN_SEL == '0 || LEN_SEL > LW'(LEN))
            len_in = LW'(LEN);
    end

    // len_q is never below 1, so len_q-1 never underflows.
    always_comb begin
        last_pos  = (LW'(pos) == (len_q - LW'(1)));
        wrap_step = E & last_pos;
        pos_nxt   = pos;
        if (wrap_step)
            pos_nxt = '0;
        else if (E)
            pos_nxt = pos + PW'(1);
    end

    always_ff @(posedge iCLK) begin
        if (RST) begin
            pos        <= '0;
            len_q      <= LW'(LEN);
            shadow_len <= LW'(LEN);
            pend       <= 1'b0;
            oSTB       <= '0;
            oWRAP      <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                live[c]   <= DEFAULT_MASK;
                shadow[c] <= DEFAULT_MASK;
            end
        end else begin
            pos   <= pos_nxt;
            oWRAP <= wrap_step;
            // The wrap-step strobe still reads the outgoing mask: the last
            // position belongs to the period that is ending.
            for (int c = 0; c < NCH; c++)
                oSTB[c] <= E & live[c][pos];

            if (LOAD) begin
                shadow_len <= len_in;
                for (int c = 0; c < NCH; c++)
                    shadow[c] <= MASK_IN[c*LEN +: LEN];
            end

            // A load coinciding with the wrap step goes straight to live,
            // skipping the shadow stage; otherwise a pending shadow commits.
            if (wrap_step && LOAD) begin
                len_q <= len_in;
                pend  <= 1'b0;
                for (int c = 0; c < NCH; c++)
                    live[c] <= MASK_IN[c*LEN +: LEN];
            end else if (wrap_step && pend) begin
                len_q <= shadow_len;
                pend  <= 1'b0;
                for (int c = 0; c < NCH; c++)
                    live[c] <= shadow[c];
            end else if (LOAD) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++)
            oB0[c] = live[c][pos];
    end

    assign oPOS = pos;

`ifdef SKIPRING_MC_CNT_EN
    logic [15:0] cnt [NCH];

    always_ff @(posedge iCLK) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++)
                cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++)
                if (oSTB[c])
                    cnt[c] <= cnt[c] + 16'd1;
        end
    end

    always_comb begin
        oCNT = '0;
        for (int c = 0; c < NCH; c++)
            oCNT[c*16 +: 16] = cnt[c];
    end
`else
    assign oCNT = '0;
`endif

endmodule

// File: tb/tb_skipring_mc.sv
module tb_skipring_mc;

    localparam int LEN = 16;
    localparam int NCH = 2;
    localparam logic [15:0] DEF = 16'b0011010001000101;

    logic        iCLK;
    logic        RST;
    logic        E;
    logic        LOAD;
    logic [31:0] MASK_IN;
    logic [4:0]  LEN_SEL;
    logic [1:0]  oSTB;
    logic [1:0]  oB0;
    logic        oWRAP;
    logic [3:0]  oPOS;
    logic [31:0] oCNT;

    skipring_mc #(.LEN(LEN), .NCH(NCH), .DEFAULT_MASK(DEF)) dut (
        .iCLK(iCLK), .RST(RST), .E(E), .LOAD(LOAD), .MASK_IN(MASK_IN),
        .LEN_SEL(LEN_SEL), .oSTB(oSTB), .oB0(oB0), .oWRAP(oWRAP),
        .oPOS(oPOS), .oCNT(oCNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [1:0]  stb;
        logic        wrap;
        logic [3:0]  pos;
        logic [1:0]  b0;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int stepno = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int wraps = 0;

    // reference model state
    int          m_pos;
    int          m_len;
    int          m_shlen;
    logic        m_pend;
    logic [15:0] m_live [2];
    logic [15:0] m_sh   [2];
    logic [1:0]  m_stb;
    logic [15:0] m_cnt  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, expv);
        end
    endtask

    function automatic exp_t snap();
        exp_t x;
        x.stb  = m_stb;
        x.pos  = 4'(m_pos);
        x.b0   = {m_live[1][m_pos], m_live[0][m_pos]};
`ifdef SKIPRING_MC_CNT_EN
        x.cnt  = {m_cnt[1], m_cnt[0]};
`else
        x.cnt  = 32'h0;
`endif
        x.wrap = 1'b0;
        return x;
    endfunction

    task automatic edge_and_compare();
        exp_t x;
        @(posedge iCLK);
        #1;
        stepno++;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            x = q.pop_front();
            chk("stb",  32'(oSTB),  32'(x.stb));
            chk("wrap", 32'(oWRAP), 32'(x.wrap));
            chk("pos",  32'(oPOS),  32'(x.pos));
            chk("b0",   32'(oB0),   32'(x.b0));
            chk("cnt",  oCNT,       x.cnt);
        end
        pulses0 += int'(oSTB[0]);
        pulses1 += int'(oSTB[1]);
        wraps   += int'(oWRAP);
    endtask

    task automatic do_reset();
        exp_t x;
        RST = 1'b1; E = 1'b0; LOAD = 1'b0; MASK_IN = '0; LEN_SEL = '0;
        m_pos = 0; m_len = 16; m_shlen = 16; m_pend = 1'b0; m_stb = 2'b00;
        for (int c = 0; c < 2; c++) begin
            m_live[c] = DEF; m_sh[c] = DEF; m_cnt[c] = 16'h0;
        end
        x = snap();
        q.push_back(x);
        edge_and_compare();
        RST = 1'b0;
    endtask

    task automatic step(input logic e, input logic ld = 1'b0,
                        input logic [31:0] mi = 32'h0, input logic [4:0] ls = 5'd0);
        exp_t x;
        logic wr;
        int   cl;
        logic [1:0] ns;
        RST = 1'b0; E = e; LOAD = ld; MASK_IN = mi; LEN_SEL = ls;
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = m_cnt[c] + 16'(m_stb[c]);
            ns[c] = e & m_live[c][m_pos];
        end
        wr = e && (m_pos == m_len - 1);
        if (wr) m_pos = 0;
        else if (e) m_pos = m_pos + 1;
        cl = (ls == 0 || ls > 16) ? 16 : int'(ls);
        if (wr && ld) begin
            m_live[0] = mi[15:0]; m_live[1] = mi[31:16]; m_len = cl; m_pend = 1'b0;
        end else if (wr && m_pend) begin
            m_live[0] = m_sh[0]; m_live[1] = m_sh[1]; m_len = m_shlen; m_pend = 1'b0;
        end else if (ld) begin
            m_sh[0] = mi[15:0]; m_sh[1] = mi[31:16]; m_shlen = cl; m_pend = 1'b1;
        end
        m_stb = ns;
        x = snap();
        x.wrap = wr;
        q.push_back(x);
        edge_and_compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic clr();
        pulses0 = 0; pulses1 = 0; wraps = 0;
    endtask

    initial begin
        RST = 1'b1; E = 1'b0; LOAD = 1'b0; MASK_IN = '0; LEN_SEL = '0;

        // 1: default pattern, one full period
        do_reset();
        chk("rst_pos", 32'(oPOS), 32'd0);
        chk("rst_stb", 32'(oSTB), 32'd0);
        clr();
        run(16);
        chk("t1_pulses0", 32'(pulses0), 32'd6);
        chk("t1_pulses1", 32'(pulses1), 32'd6);
        chk("t1_wraps", 32'(wraps), 32'd1);
        chk("t1_wrap_last", 32'(oWRAP), 32'd1);

        // 2: load mid-period commits at wrap with the new length
        run(5);
        chk("t2_pos5", 32'(oPOS), 32'd5);
        clr();
        step(1'b1, 1'b1, {16'hF0F0, 16'h0001}, 5'd4);
        run(10);
        chk("t2_old_pulses", 32'(pulses0), 32'd4);
        chk("t2_old_wrap", 32'(oWRAP), 32'd1);
        clr();
        run(4);
        chk("t2_new_pulses0", 32'(pulses0), 32'd1);
        chk("t2_new_pulses1", 32'(pulses1), 32'd0);
        chk("t2_new_wrap", 32'(oWRAP), 32'd1);
        chk("t2_new_wraps", 32'(wraps), 32'd1);

        // 3: load on the exact wrap step
        do_reset();
        run(15);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0);
        chk("t3_wrap_stb_old", 32'(oSTB[0]), 32'd0);
        chk("t3_wrap", 32'(oWRAP), 32'd1);
        clr();
        run(16);
        chk("t3_new_pulses", 32'(pulses0), 32'd16);

        // 4: enable toggling
        do_reset();
        step(1'b1); chk("t4_pos_a", 32'(oPOS), 32'd1);
        step(1'b0); chk("t4_pos_b", 32'(oPOS), 32'd1);
        chk("t4_stb_b", 32'(oSTB), 32'd0);
        step(1'b1); chk("t4_pos_c", 32'(oPOS), 32'd2);
        step(1'b0); chk("t4_pos_d", 32'(oPOS), 32'd2);
        chk("t4_wrap_d", 32'(oWRAP), 32'd0);

        // 5: reset discards a pending load
        do_reset();
        run(9);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd4);
        do_reset();
        chk("t5_pos", 32'(oPOS), 32'd0);
        chk("t5_b0", 32'(oB0), 32'd3);
        clr();
        run(32);
        chk("t5_pulses", 32'(pulses0), 32'd12);
        chk("t5_wraps", 32'(wraps), 32'd2);

        // length 1 and out-of-range length clamp
        do_reset();
        step(1'b0, 1'b1, {16'h0000, 16'h0001}, 5'd1);
        run(16);
        clr();
        run(3);
        chk("len1_wraps", 32'(wraps), 32'd3);
        chk("len1_pulses", 32'(pulses0), 32'd3);
        step(1'b1, 1'b1, {16'h0000, 16'h0002}, 5'd20);
        clr();
        run(16);
        chk("clamp_wraps", 32'(wraps), 32'd1);
        chk("clamp_pulses", 32'(pulses0), 32'd1);

        // 6: strobe counters over three periods
        do_reset();
        run(48);
`ifdef SKIPRING_MC_CNT_EN
        chk("t6_cnt0", 32'(oCNT[15:0]), 32'd18);
`else
        chk("t6_cnt0", 32'(oCNT[15:0]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
